// File: rtl/ahb_slave_port_mux.sv
// ahb_slave_port_mux: per-slave address/control mux, data-phase owner tracking and response return.
// Optional build macro AHB_MUX_ONEHOT_CHECK_EN: a multi-hot hgrant is answered with a two-cycle ERROR.
module ahb_slave_port_mux #(
    parameter int MASTER_NUM = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                 hclk,
    input  logic                                 hreset_n,
    input  logic [MASTER_NUM-1:0]                hgrant,
    input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0] m_haddr,
    input  logic [MASTER_NUM-1:0][1:0]           m_htrans,
    input  logic [MASTER_NUM-1:0]                m_hwrite,
    input  logic [MASTER_NUM-1:0][2:0]           m_hsize,
    input  logic [MASTER_NUM-1:0][2:0]           m_hburst,
    input  logic [MASTER_NUM-1:0][DATA_WIDTH-1:0] m_hwdata,
    output logic [DATA_WIDTH-1:0]                m_hrdata,
    output logic [MASTER_NUM-1:0]                m_hready,
    output logic [MASTER_NUM-1:0]                m_hresp,
    output logic                                 s_hsel,
    output logic [ADDR_WIDTH-1:0]                s_haddr,
    output logic [1:0]                           s_htrans,
    output logic                                 s_hwrite,
    output logic [2:0]                           s_hsize,
    output logic [2:0]                           s_hburst,
    output logic [DATA_WIDTH-1:0]                s_hwdata,
    input  logic                                 s_hreadyout,
    input  logic [DATA_WIDTH-1:0]                s_hrdata,
    input  logic                                 s_hresp,
    output logic                                 hwait
);

    // state | meaning
    // OKAY  | slave hreadyout/hresp passed straight through
    // ERR1  | first ERROR cycle: hready low, slave sees IDLE
    // ERR2  | second ERROR cycle: hready high, data-phase owner dropped
    localparam logic [1:0] ST_OKAY = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [MASTER_NUM-1:0] r_dphase_owner;
    logic                  r_dphase_write;
    logic [4:0]            r_beat_cnt;

    logic                  w_hready_int;
    logic                  w_resp;
    logic                  w_grant_err;
    logic                  w_force_idle;
    logic                  w_addr_active;
    logic                  w_nonseq_acc;
    logic                  w_beat_done;

    logic [ADDR_WIDTH-1:0] w_sel_haddr;
    logic [1:0]            w_sel_htrans;
    logic                  w_sel_hwrite;
    logic [2:0]            w_sel_hsize;
    logic [2:0]            w_sel_hburst;
    logic [DATA_WIDTH-1:0] w_dp_hwdata;

`ifdef AHB_MUX_ONEHOT_CHECK_EN
    localparam logic [MASTER_NUM-1:0] GRANT_ONE = MASTER_NUM'(1);
    logic w_multi_hot;
    assign w_multi_hot = |(hgrant & (hgrant - GRANT_ONE));
    assign w_grant_err = w_multi_hot;
`else
    assign w_grant_err = 1'b0;
`endif

    // Descending scan so the lowest-index granted master wins on a multi-hot grant.
    always_comb begin
        w_sel_haddr  = '0;
        w_sel_htrans = HTRANS_IDLE;
        w_sel_hwrite = 1'b0;
        w_sel_hsize  = '0;
        w_sel_hburst = '0;
        for (int i = MASTER_NUM - 1; i >= 0; i--) begin
            if (hgrant[i]) begin
                w_sel_haddr  = m_haddr[i];
                w_sel_htrans = m_htrans[i];
                w_sel_hwrite = m_hwrite[i];
                w_sel_hsize  = m_hsize[i];
                w_sel_hburst = m_hburst[i];
            end
        end
    end

    always_comb begin
        w_dp_hwdata = '0;
        for (int i = MASTER_NUM - 1; i >= 0; i--) begin
            if (r_dphase_owner[i]) begin
                w_dp_hwdata = m_hwdata[i];
            end
        end
    end

    // Both ERROR cycles hide the address phase from the slave; ERR2 drops ownership anyway.
    assign w_force_idle = (r_state != ST_OKAY) | w_grant_err;

    assign s_hsel   = |hgrant;
    assign s_haddr  = w_sel_haddr;
    assign s_htrans = w_force_idle ? HTRANS_IDLE : w_sel_htrans;
    assign s_hwrite = w_sel_hwrite;
    assign s_hsize  = w_sel_hsize;
    assign s_hburst = w_sel_hburst;
    assign s_hwdata = w_dp_hwdata;

    always_comb begin
        case (r_state)
            ST_OKAY: begin
                w_hready_int = s_hreadyout;
                w_resp       = s_hresp;
            end
            ST_ERR1: begin
                w_hready_int = 1'b0;
                w_resp       = 1'b1;
            end
            ST_ERR2: begin
                w_hready_int = 1'b1;
                w_resp       = 1'b1;
            end
            default: begin
                w_hready_int = s_hreadyout;
                w_resp       = s_hresp;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OKAY: begin
                if (w_hready_int && w_grant_err) begin
                    w_state_nxt = ST_ERR1;
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            ST_ERR2: w_state_nxt = ST_OKAY;
            default: w_state_nxt = ST_OKAY;
        endcase
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state <= ST_OKAY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_addr_active = s_htrans[1];
    assign w_nonseq_acc  = w_hready_int && (s_htrans == HTRANS_NONSEQ);
    assign w_beat_done   = w_hready_int && (|r_dphase_owner);

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_dphase_owner <= '0;
            r_dphase_write <= 1'b0;
        end else if (r_state == ST_ERR2) begin
            r_dphase_owner <= '0;
            r_dphase_write <= 1'b0;
        end else if (w_hready_int) begin
            r_dphase_write <= s_hwrite;
            // Flagged masters keep ownership so each one receives the ERROR response.
            if (w_grant_err || w_addr_active) begin
                r_dphase_owner <= hgrant;
            end else begin
                r_dphase_owner <= '0;
            end
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_beat_cnt <= '0;
        end else if (w_nonseq_acc) begin
            r_beat_cnt <= '0;
        end else if (w_beat_done && (r_beat_cnt != 5'd16)) begin
            r_beat_cnt <= r_beat_cnt + 5'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < MASTER_NUM; i++) begin
            m_hready[i] = (r_dphase_owner[i] || hgrant[i]) ? w_hready_int : 1'b1;
            m_hresp[i]  = r_dphase_owner[i] ? w_resp : 1'b0;
        end
    end

    assign m_hrdata = s_hrdata;
    assign hwait    = ~w_hready_int;

    a_beat_sat: assert property (@(posedge hclk) disable iff (!hreset_n)
        r_beat_cnt <= 5'd16);
    a_state_legal: assert property (@(posedge hclk) disable iff (!hreset_n)
        (r_state == ST_OKAY) || (r_state == ST_ERR1) || (r_state == ST_ERR2));
    a_err_seq: assert property (@(posedge hclk) disable iff (!hreset_n)
        (r_state == ST_ERR1) |=> (r_state == ST_ERR2));
    a_err_clr: assert property (@(posedge hclk) disable iff (!hreset_n)
        (r_state == ST_ERR2) |=> ((r_dphase_owner == '0) && !r_dphase_write && (r_state == ST_OKAY)));

endmodule

// File: tb/tb_ahb_slave_port_mux.sv
// Scoreboard bench for ahb_slave_port_mux: driver pushes model predictions, negedge monitor compares.
// Honours AHB_MUX_ONEHOT_CHECK_EN the same way the design does.
module tb_ahb_slave_port_mux;
    localparam int MN = 2;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef AHB_MUX_ONEHOT_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic                   hclk = 1'b0;
    logic                   hreset_n = 1'b0;
    logic [MN-1:0]          hgrant = '0;
    logic [MN-1:0][AW-1:0]  m_haddr = '0;
    logic [MN-1:0][1:0]     m_htrans = '0;
    logic [MN-1:0]          m_hwrite = '0;
    logic [MN-1:0][2:0]     m_hsize = '0;
    logic [MN-1:0][2:0]     m_hburst = '0;
    logic [MN-1:0][DW-1:0]  m_hwdata = '0;
    logic [DW-1:0]          m_hrdata;
    logic [MN-1:0]          m_hready;
    logic [MN-1:0]          m_hresp;
    logic                   s_hsel;
    logic [AW-1:0]          s_haddr;
    logic [1:0]             s_htrans;
    logic                   s_hwrite;
    logic [2:0]             s_hsize;
    logic [2:0]             s_hburst;
    logic [DW-1:0]          s_hwdata;
    logic                   s_hreadyout = 1'b1;
    logic [DW-1:0]          s_hrdata = '0;
    logic                   s_hresp = 1'b0;
    logic                   hwait;

    always #5 hclk = ~hclk;

    ahb_slave_port_mux #(.MASTER_NUM(MN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .hclk(hclk), .hreset_n(hreset_n), .hgrant(hgrant),
        .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
        .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata),
        .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
        .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
        .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hwdata(s_hwdata),
        .s_hreadyout(s_hreadyout), .s_hrdata(s_hrdata), .s_hresp(s_hresp), .hwait(hwait)
    );

    typedef struct {
        logic [AW-1:0] haddr;
        logic [1:0]    htrans;
        logic          hwrite;
        logic [2:0]    hsize;
        logic [2:0]    hburst;
        logic          hsel;
        logic [DW-1:0] hwdata;
        logic [DW-1:0] hrdata;
        logic [MN-1:0] hready;
        logic [MN-1:0] hresp;
        logic          hwait;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: which masters own the data phase, and how many ERROR cycles remain.
    logic [MN-1:0] own = '0;
    int err_left = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [MN-1:0] m);
        for (int i = 0; i < MN; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        int g, o;
        logic hr, rs;
        hr = (err_left == 2) ? 1'b0 : ((err_left == 1) ? 1'b1 : s_hreadyout);
        rs = (err_left > 0) ? 1'b1 : s_hresp;
        e = '{default: '0};
        g = lowest(hgrant);
        if (g >= 0) begin
            e.haddr  = m_haddr[g];
            e.htrans = m_htrans[g];
            e.hwrite = m_hwrite[g];
            e.hsize  = m_hsize[g];
            e.hburst = m_hburst[g];
        end
        if (err_left > 0 || (CHK_EN && $countones(hgrant) > 1)) e.htrans = 2'b00;
        e.hsel = (hgrant != '0);
        o = lowest(own);
        e.hwdata = (o >= 0) ? m_hwdata[o] : '0;
        e.hrdata = s_hrdata;
        for (int i = 0; i < MN; i++) begin
            e.hready[i] = (own[i] || hgrant[i]) ? hr : 1'b1;
            e.hresp[i]  = own[i] ? rs : 1'b0;
        end
        e.hwait = !hr;
        return e;
    endfunction

    function automatic void advance();
        exp_t e;
        if (!hreset_n) begin
            own = '0;
            err_left = 0;
            return;
        end
        e = predict();
        if (err_left == 1) begin
            own = '0;
            err_left = 0;
        end else if (err_left == 2) begin
            err_left = 1;
        end else if (!e.hwait) begin
            if (CHK_EN && $countones(hgrant) > 1) begin
                own = hgrant;
                err_left = 2;
            end else begin
                own = (e.htrans >= 2'd2) ? hgrant : '0;
            end
        end
    endfunction

    task automatic cycle();
        q.push_back(predict());
        @(posedge hclk);
        advance();
        #1;
    endtask

    task automatic set_idle();
        hgrant = '0;
        m_htrans = '0;
        s_hreadyout = 1'b1;
        s_hresp = 1'b0;
    endtask

    task automatic rand_inputs();
        int r;
        for (int i = 0; i < MN; i++) begin
            m_haddr[i]  = $urandom;
            m_htrans[i] = 2'($urandom_range(0, 3));
            m_hwrite[i] = 1'($urandom_range(0, 1));
            m_hsize[i]  = 3'($urandom_range(0, 2));
            m_hburst[i] = 3'($urandom_range(0, 7));
            m_hwdata[i] = $urandom;
        end
        r = $urandom_range(0, 15);
        hgrant = (r < 4) ? 2'b00 : (r < 9) ? 2'b01 : (r < 14) ? 2'b10 : 2'b11;
        s_hreadyout = ($urandom_range(0, 3) != 0);
        s_hresp = ($urandom_range(0, 7) == 0);
        s_hrdata = $urandom;
    endtask

    always @(negedge hclk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("s_haddr",  s_haddr,  e.haddr);
            chk("s_htrans", s_htrans, e.htrans);
            chk("s_hwrite", s_hwrite, e.hwrite);
            chk("s_hsize",  s_hsize,  e.hsize);
            chk("s_hburst", s_hburst, e.hburst);
            chk("s_hsel",   s_hsel,   e.hsel);
            chk("s_hwdata", s_hwdata, e.hwdata);
            chk("m_hrdata", m_hrdata, e.hrdata);
            chk("m_hready", m_hready, e.hready);
            chk("m_hresp",  m_hresp,  e.hresp);
            chk("hwait",    hwait,    e.hwait);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(posedge hclk);
        #1;
        // Reset
        set_idle();
        #1;
        chk("rst_htrans", s_htrans, 2'b00);
        chk("rst_hsel",   s_hsel,   1'b0);
        chk("rst_hresp",  m_hresp,  2'b00);
        chk("rst_hready", m_hready, 2'b11);
        cycle();
        cycle();
        hreset_n = 1'b1;
        cycle();

        // Single write from m1
        hgrant = 2'b10; m_htrans[1] = 2'b10; m_haddr[1] = 32'h100; m_hwrite[1] = 1'b1;
        m_hwdata[1] = 32'h0;
        #1;
        chk("wr_haddr", s_haddr, 32'h100);
        cycle();
        set_idle(); m_hwdata[1] = 32'hA5A5_0001;
        #1;
        chk("wr_hwdata", s_hwdata, 32'hA5A5_0001);
        chk("wr_hready1", m_hready[1], 1'b1);
        cycle();

        // Read from m0 with three wait states
        hgrant = 2'b01; m_htrans[0] = 2'b10; m_haddr[0] = 32'h200; m_hwrite[0] = 1'b0;
        cycle();
        for (int k = 0; k < 3; k++) begin
            set_idle(); s_hreadyout = 1'b0; m_hwdata[0] = 32'h0BAD_0000;
            #1;
            chk("ws_hwait", hwait, 1'b1);
            chk("ws_hready0", m_hready[0], 1'b0);
            chk("ws_owner_held", s_hwdata, 32'h0BAD_0000);
            cycle();
        end
        s_hreadyout = 1'b1; s_hrdata = 32'hDEAD_BEEF;
        #1;
        chk("ws_rdata", m_hrdata, 32'hDEAD_BEEF);
        chk("ws_release", m_hready[0], 1'b1);
        chk("ws_hwait_low", hwait, 1'b0);
        cycle();

        // Back-to-back handover m0 -> m1
        set_idle();
        hgrant = 2'b01; m_htrans[0] = 2'b10; m_haddr[0] = 32'h300; m_hwrite[0] = 1'b1;
        cycle();
        hgrant = 2'b10; m_htrans = '0; m_htrans[1] = 2'b10; m_haddr[1] = 32'h400;
        m_hwdata[0] = 32'h1111_0000; m_hwdata[1] = 32'h2222_0000;
        #1;
        chk("ho_haddr", s_haddr, 32'h400);
        chk("ho_hwdata_m0", s_hwdata, 32'h1111_0000);
        cycle();
        set_idle();
        #1;
        chk("ho_hwdata_m1", s_hwdata, 32'h2222_0000);
        cycle();

        // Slave-generated two-cycle ERROR to m0
        hgrant = 2'b01; m_htrans[0] = 2'b10; m_haddr[0] = 32'h500;
        cycle();
        set_idle(); s_hresp = 1'b1; s_hreadyout = 1'b0;
        #1;
        chk("se_resp1", m_hresp, 2'b01);
        cycle();
        s_hresp = 1'b1; s_hreadyout = 1'b1;
        #1;
        chk("se_resp2", m_hresp, 2'b01);
        cycle();
        set_idle();
        cycle();

`ifdef AHB_MUX_ONEHOT_CHECK_EN
        hgrant = 2'b11; m_htrans[0] = 2'b10; m_htrans[1] = 2'b10;
        #1;
        chk("oh_idle", s_htrans, 2'b00);
        cycle();
        set_idle();
        #1;
        chk("oh_resp1", m_hresp, 2'b11);
        chk("oh_ready1", m_hready, 2'b00);
        cycle();
        #1;
        chk("oh_resp2", m_hresp, 2'b11);
        chk("oh_ready2", m_hready, 2'b11);
        cycle();
        #1;
        chk("oh_okay", m_hresp, 2'b00);
        cycle();
`endif

        // Reset in the middle of a stalled transfer
        hgrant = 2'b01; m_htrans[0] = 2'b10; m_hwdata[0] = 32'h7777_7777;
        cycle();
        set_idle(); s_hreadyout = 1'b0;
        cycle();
        hreset_n = 1'b0;
        own = '0; err_left = 0;
        #1;
        chk("mr_hwdata", s_hwdata, 32'h0);
        chk("mr_hresp", m_hresp, 2'b00);
        cycle();
        hreset_n = 1'b1; s_hreadyout = 1'b1;
        cycle();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            rand_inputs();
            cycle();
        end
        set_idle();
        cycle();
        @(negedge hclk);
        #1;
        chk("queue_drain", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_slave_port_mux.md
# ahb_slave_port_mux

Per-slave datapath stage sitting directly downstream of the per-slave AHB arbiter. It uses the arbiter's one-hot `hgrant` to route the granted master's address/control onto the slave port, tracks which master owns the pipelined data phase, routes `hwdata` forward and `hrdata`/`hready`/`hresp` back, and returns `hwait` to the arbiter. One instance per slave port in the generated interconnect.

## Interface
- `MASTER_NUM`, 2, number of masters that can reach this slave; equals the arbiter's `SLAVE_X_MASTER_NUM`.
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data bus width.

- `hclk`  in  1  clock; all state on rising edge.
- `hreset_n`  in  1  reset, asynchronous, active-low.
- `hgrant`  in  MASTER_NUM  one-hot address-phase grant from the arbiter.
- `m_haddr`  in  MASTER_NUM×ADDR_WIDTH  per-master address.
- `m_htrans`  in  MASTER_NUM×2  per-master HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- `m_hwrite`  in  MASTER_NUM  per-master write flag.
- `m_hsize`  in  MASTER_NUM×3  per-master HSIZE.
- `m_hburst`  in  MASTER_NUM×3  per-master HBURST (`hburst_type` encoding).
- `m_hwdata`  in  MASTER_NUM×DATA_WIDTH  per-master write data.
- `m_hrdata`  out  DATA_WIDTH  read data broadcast to all masters.
- `m_hready`  out  MASTER_NUM  per-master HREADY.
- `m_hresp`  out  MASTER_NUM  per-master HRESP (0=OKAY, 1=ERROR).
- `s_hsel`  out  1  slave select.
- `s_haddr`, `s_htrans`, `s_hwrite`, `s_hsize`, `s_hburst`  out  as above  muxed address/control.
- `s_hwdata`  out  DATA_WIDTH  muxed write data.
- `s_hreadyout`  in  1  slave ready.
- `s_hrdata`  in  DATA_WIDTH  slave read data.
- `s_hresp`  in  1  slave response.
- `hwait`  out  1  to arbiter; `~hready_int`.

## Operation
- `hready_int` = `s_hreadyout` in OKAY state; driven by the response FSM otherwise.
- Address phase: `s_haddr/s_htrans/s_hwrite/s_hsize/s_hburst` = fields of master i where `hgrant[i]`=1; all zero (`s_htrans`=IDLE, `s_hburst`=SINGLE) when `hgrant`=0. `s_hsel` = `|hgrant`.
- `dphase_owner` (MASTER_NUM bits): on edge with `hready_int`=1, loads `hgrant` if selected `htrans` is NONSEQ/SEQ, else loads 0. Holds while `hready_int`=0.
- `dphase_write`: loaded with `s_hwrite` alongside `dphase_owner`.
- `s_hwdata` = `m_hwdata[i]` for `dphase_owner[i]`=1, else 0.
- `m_hrdata` = `s_hrdata` unconditionally.
- `m_hready[i]` = `hready_int` if `dphase_owner[i]` or `hgrant[i]`, else 1.
- `m_hresp[i]` = response value if `dphase_owner[i]`, else 0.
- Beat counter (5 bits): increments on each completed data beat (`hready_int`=1, `dphase_owner`≠0); cleared when a NONSEQ is accepted; saturates at 16. Not visible at ports; used only by the assertion set.
- Response FSM, states OKAY, ERR1, ERR2:
  - OKAY: pass `s_hresp`, `s_hreadyout`. To ERR1 on a local error (see Configuration).
  - ERR1: `hready_int`=0, resp=1, slave sees `s_htrans`=IDLE. → ERR2.
  - ERR2: `hready_int`=1, resp=1. → OKAY; `dphase_owner` cleared.
- Slave-generated two-cycle ERROR passes through unmodified in OKAY state.

## Timing
- Address/control path: purely combinational from `hgrant`/`m_*`, zero latency.
- Data phase lags the address phase by one accepted cycle; wait states stretch it by holding `dphase_owner`.
- `hwait` combinational from `s_hreadyout` and FSM state.
- Reset values: `dphase_owner`=0, `dphase_write`=0, FSM=OKAY, beat counter=0; hence `s_hwdata`=0, `m_hresp`=0, `m_hready` all 1 when `s_hreadyout`=1.
- Grant change with `hready_int`=0: address mux follows `hgrant`; `dphase_owner` does not change until the stall ends.
- Reset asserted mid-transfer: all state clears immediately; in-flight beat abandoned, no response generated.

## Configuration
- `AHB_MUX_ONEHOT_CHECK_EN` defined: on a cycle with `hready_int`=1 and `hgrant` not zero-or-one-hot, the FSM enters ERR1; the address phase is forced to IDLE, `dphase_owner` loads `hgrant`, and every flagged master receives the two-cycle ERROR.
- Not defined: no check; for multi-hot `hgrant` the lowest-index set bit selects the address mux, FSM never leaves OKAY.

## Test plan
- Reset: `hreset_n`=0 → `s_htrans`=0, `s_hsel`=0, `m_hresp`=0, `m_hready`=2'b11 with `s_hreadyout`=1.
- Single write: `hgrant`=2'b10, m1 NONSEQ addr 0x100 data 0xA5A5_0001 → `s_haddr`=0x100 same cycle, `s_hwdata`=0xA5A5_0001 next cycle, `m_hready[1]`=1.
- Wait states: read from m0 with `s_hreadyout` low 3 cycles → `hwait`=1 three cycles, `m_hready[0]`=0 three cycles, `dphase_owner`=2'b01 held, data 0xDEAD_BEEF on release.
- Back-to-back handover: m0 NONSEQ then m1 NONSEQ next cycle → `s_hwdata` shows m0 data while `s_haddr` shows m1 address.
- Slave ERROR: `s_hresp`=1 with `s_hreadyout` 0 then 1 → `m_hresp[owner]`=1 both cycles, non-owner resp 0.
- With `AHB_MUX_ONEHOT_CHECK_EN`: `hgrant`=2'b11 → `s_htrans`=IDLE, next two cycles `m_hresp`=2'b11, `m_hready`=00 then 11, FSM back to OKAY.
